// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: the first set request at or after ptr wins.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the farthest candidate back to ptr so the nearest one is written last.
    always_comb begin
        int cand;
        cand = 0;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = (int'(ptr) + k) % N_REQ;
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ byte requesters,
// with busy tracking, busy-rise timeout and a programmable inter-frame gap.
module uart_tx_arbiter
    import uart_tx_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [N_REQ-1:0]           REQ_VALID,
    input  logic [8*N_REQ-1:0]         REQ_DATA,
    input  logic [N_REQ-1:0]           REQ_PAR_EN,
    input  logic [N_REQ-1:0]           REQ_PAR_TYP,
    output logic [N_REQ-1:0]           REQ_READY,
    input  logic                       TX_BUSY,
    output logic [7:0]                 TX_P_DATA,
    output logic                       TX_DATA_VALID,
    output logic                       TX_PAR_EN,
    output logic                       TX_PAR_TYP,
    output logic [$clog2(N_REQ)-1:0]   GRANT_ID,
    output logic                       ARB_BUSY,
    output logic                       TIMEOUT_ERR
);

    localparam int ID_W    = $clog2(N_REQ);
    localparam int CNT_MAX = (GAP_CYCLES > BUSY_TIMEOUT) ? GAP_CYCLES : BUSY_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(BUSY_TIMEOUT - 1);
    // A zero gap still spends one clock in GAP.
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  win_idx;
    logic [N_REQ-1:0] win_gnt;
    logic             win_any;
    logic             accept;
    logic             busy_timeout;
    logic [7:0]       sel_data;
    logic             sel_par_en;
    logic             sel_par_typ;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .req (REQ_VALID),
        .ptr (rr_ptr),
        .gnt (win_gnt),
        .idx (win_idx),
        .any (win_any)
    );

    always_comb begin
        sel_data    = 8'h00;
        sel_par_en  = 1'b0;
        sel_par_typ = PAR_EVEN;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_gnt[i]) begin
                sel_data    = REQ_DATA[8*i +: 8];
                sel_par_en  = REQ_PAR_EN[i];
                sel_par_typ = REQ_PAR_TYP[i];
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        busy_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (!RST && win_any && !TX_BUSY) begin
                    accept    = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH:    state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (TX_BUSY) begin
                    state_nxt = WAIT_DONE;
                end else if (cnt == TO_LAST) begin
                    busy_timeout = 1'b1;
                    state_nxt    = GAP;
                end
            end
            WAIT_DONE: if (!TX_BUSY) state_nxt = GAP;
            GAP:       if (cnt >= GAP_LAST) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    assign REQ_READY   = accept ? win_gnt : '0;
    assign ARB_BUSY    = (state != IDLE);
    assign TIMEOUT_ERR = busy_timeout;

    // The shared counter restarts on every state change and saturates otherwise.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            cnt           <= '0;
            rr_ptr        <= '0;
            GRANT_ID      <= '0;
            TX_P_DATA     <= 8'h00;
            TX_DATA_VALID <= 1'b0;
            TX_PAR_EN     <= 1'b0;
            TX_PAR_TYP    <= PAR_EVEN;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (cnt != CNT_SAT) begin
                cnt <= cnt + 1'b1;
            end
            TX_DATA_VALID <= accept;
            if (accept) begin
                TX_P_DATA  <= sel_data;
                TX_PAR_EN  <= sel_par_en;
                TX_PAR_TYP <= sel_par_typ;
                GRANT_ID   <= win_idx;
                rr_ptr     <= (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter with a behavioural transmitter model.
module tb_uart_tx_arbiter;
    import uart_tx_pkg::*;

    localparam int N    = 4;
    localparam int GAP  = 2;
    localparam int TO   = 16;
    localparam int GAPE = (GAP > 0) ? GAP : 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_par_en = '0;
    logic [N-1:0]   req_par_typ = '0;
    logic [N-1:0]   req_ready;
    logic           tx_busy;
    logic           model_busy = 1'b0;
    logic           foreign_busy = 1'b0;
    logic [7:0]     tx_p_data;
    logic           tx_data_valid, tx_par_en, tx_par_typ;
    logic [1:0]     grant_id;
    logic           arb_busy, timeout_err;

    assign tx_busy = model_busy | foreign_busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ        (N),
        .GAP_CYCLES   (GAP),
        .BUSY_TIMEOUT (TO)
    ) dut (
        .CLK           (clk),
        .RST           (rst),
        .REQ_VALID     (req_valid),
        .REQ_DATA      (req_data),
        .REQ_PAR_EN    (req_par_en),
        .REQ_PAR_TYP   (req_par_typ),
        .REQ_READY     (req_ready),
        .TX_BUSY       (tx_busy),
        .TX_P_DATA     (tx_p_data),
        .TX_DATA_VALID (tx_data_valid),
        .TX_PAR_EN     (tx_par_en),
        .TX_PAR_TYP    (tx_par_typ),
        .GRANT_ID      (grant_id),
        .ARB_BUSY      (arb_busy),
        .TIMEOUT_ERR   (timeout_err)
    );

    typedef struct {
        logic [7:0] data;
        logic       pen;
        logic       ptyp;
        int         id;
        int         cyc;
    } launch_t;

    launch_t    sb[$];
    launch_t    last_l;
    launch_t    m_e;
    int         gseq[$];
    logic [7:0] ldata[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dv_seen = 0;
    int timeouts = 0;
    logic [N-1:0] acc_mask = '0;
    logic rst_prev = 1'b0;
    logic tx_mute = 1'b0;
    int auto_mode = 0;

    // Reference model: 0 = free (idle from 'earliest'), 1 = launched at lcyc, 2 = waiting for busy to fall.
    int phase = 0;
    int earliest = 0;
    int ptr = 0;
    int lcyc = 0;
    logic m_exp_acc, m_exp_to, m_exp_arb;
    int m_w, m_act;
    int tx_st = 0, tx_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input int p, input logic [N-1:0] v);
        int best;
        int bestd;
        best = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
            if (v[i] && ((i - p + N) % N) < bestd) begin
                bestd = (i - p + N) % N;
                best = i;
            end
        end
        return best;
    endfunction

    // Transmitter model: busy rises 1..3 clocks after the launch pulse and stays high 2..8 clocks.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                model_busy = 1'b0;
                tx_st = 0;
            end else begin
                case (tx_st)
                    0: if (tx_data_valid && !tx_mute) begin
                        tx_cnt = $urandom_range(1, 3);
                        tx_st = 1;
                    end
                    1: begin
                        tx_cnt--;
                        if (tx_cnt == 0) begin
                            model_busy = 1'b1;
                            tx_cnt = $urandom_range(2, 8);
                            tx_st = 2;
                        end
                    end
                    default: begin
                        tx_cnt--;
                        if (tx_cnt == 0) begin
                            model_busy = 1'b0;
                            tx_st = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Monitor and scoreboard, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                if (rst_prev) begin
                    chk("rst_tx_p_data", tx_p_data, 0);
                    chk("rst_tx_data_valid", tx_data_valid, 0);
                    chk("rst_tx_par_en", tx_par_en, 0);
                    chk("rst_tx_par_typ", tx_par_typ, 0);
                    chk("rst_grant_id", grant_id, 0);
                    chk("rst_arb_busy", arb_busy, 0);
                    chk("rst_timeout_err", timeout_err, 0);
                end
                if (rst) begin
                    chk("ready_in_reset", req_ready, 0);
                    phase = 0;
                    earliest = 0;
                    ptr = 0;
                    sb.delete();
                    acc_mask = '0;
                end else begin
                    m_exp_arb = !(phase == 0 && cyc >= earliest);
                    chk("arb_busy", arb_busy, m_exp_arb);

                    if (tx_data_valid) begin
                        dv_seen++;
                        ldata.push_back(tx_p_data);
                    end
                    if (sb.size() > 0 && sb[0].cyc == cyc) begin
                        m_e = sb.pop_front();
                        chk("launch_valid", tx_data_valid, 1);
                        chk("tx_p_data", tx_p_data, m_e.data);
                        chk("tx_par_en", tx_par_en, m_e.pen);
                        chk("tx_par_typ", tx_par_typ, m_e.ptyp);
                        chk("grant_id", grant_id, m_e.id);
                        last_l = m_e;
                    end else if (tx_data_valid) begin
                        chk("spurious_launch", tx_data_valid, 0);
                    end

                    m_exp_to = (phase == 1 && cyc == lcyc + TO && !tx_busy);
                    if (m_exp_to || timeout_err) chk("timeout_err", timeout_err, m_exp_to);
                    if (timeout_err) timeouts++;

                    if (phase == 1 && cyc > lcyc) begin
                        if (tx_busy) begin
                            phase = 2;
                        end else if (cyc == lcyc + TO) begin
                            phase = 0;
                            earliest = cyc + 1 + GAPE;
                        end
                    end else if (phase == 2 && !tx_busy) begin
                        chk("held_data", tx_p_data, last_l.data);
                        chk("held_par_en", tx_par_en, last_l.pen);
                        chk("held_par_typ", tx_par_typ, last_l.ptyp);
                        phase = 0;
                        earliest = cyc + 1 + GAPE;
                    end

                    acc_mask = req_ready;
                    m_exp_acc = (phase == 0 && cyc >= earliest && (|req_valid) && !tx_busy);
                    if (m_exp_acc) begin
                        m_w = rr_pick(ptr, req_valid);
                        chk("req_ready", req_ready, 1 << m_w);
                        m_act = -1;
                        for (int i = N - 1; i >= 0; i--) if (req_ready[i]) m_act = i;
                        gseq.push_back(m_act);
                        m_e.data = req_data[8*m_w +: 8];
                        m_e.pen = req_par_en[m_w];
                        m_e.ptyp = req_par_typ[m_w];
                        m_e.id = m_w;
                        m_e.cyc = cyc + 1;
                        sb.push_back(m_e);
                        ptr = (m_w + 1) % N;
                        phase = 1;
                        lcyc = cyc + 1;
                    end else if (req_ready != 0) begin
                        chk("ready_unexpected", req_ready, 0);
                    end
                end
                rst_prev = rst;
            end
        end
    end

    task automatic new_req(input int i, input logic [7:0] d, input logic pe, input logic pt);
        req_data[8*i +: 8] = d;
        req_par_en[i] = pe;
        req_par_typ[i] = pt;
        req_valid[i] = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc_mask;
        if (auto_mode == 1) begin
            for (int i = 0; i < N; i++)
                if (!req_valid[i]) new_req(i, 8'(8'h10 + i), 1'b0, PAR_EVEN);
        end else if (auto_mode == 2) begin
            tx_mute = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 99) < 30)
                    new_req(i, 8'($urandom), 1'($urandom), 1'($urandom));
                else if (req_valid[i] && $urandom_range(0, 99) < 2)
                    req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_launch(input int n, input int budget);
        int target;
        int b;
        target = dv_seen + n;
        b = 0;
        while (dv_seen < target && b < budget) begin
            tick();
            b++;
        end
        checks++;
        if (dv_seen < target) begin
            errors++;
            $display("FAIL wait_launch: got %0d launches, required %0d within %0d cycles", dv_seen, target, budget);
        end
    endtask

    task automatic wait_idle(input int budget);
        int b;
        b = 0;
        while (!(phase == 0 && cyc >= earliest) && b < budget) begin
            tick();
            b++;
        end
        checks++;
        if (!(phase == 0 && cyc >= earliest)) begin
            errors++;
            $display("FAIL wait_idle: still busy after %0d cycles", budget);
        end
    endtask

    initial begin
        int gs, t0, d0, b;
        int order[5];
        order = '{0, 1, 2, 3, 0};

        // Reset with every requester asserting
        rst = 1'b1;
        for (int i = 0; i < N; i++) new_req(i, 8'(8'h10 + i), 1'b1, 1'b1);
        repeat (3) tick();
        req_valid = '0;
        rst = 1'b0;
        tick();

        // Single request, then a follow-up from the same requester
        new_req(0, 8'hA5, 1'b1, PAR_ODD);
        wait_launch(1, 10);
        chk("single_data", ldata[ldata.size() - 1], 8'hA5);
        new_req(0, 8'h5A, 1'b0, PAR_EVEN);
        wait_launch(1, 60);
        wait_idle(60);

        // All four continuously valid after a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        gs = gseq.size();
        d0 = ldata.size();
        auto_mode = 1;
        req_valid = '0;
        for (int i = 0; i < N; i++) new_req(i, 8'(8'h10 + i), 1'b0, PAR_EVEN);
        wait_launch(5, 200);
        auto_mode = 0;
        req_valid = '0;
        if (gseq.size() >= gs + 5 && ldata.size() >= d0 + 5) begin
            for (int k = 0; k < 5; k++) begin
                chk("grant_order", gseq[gs + k], order[k]);
                chk("serial_order", ldata[d0 + k], 8'(8'h10 + order[k]));
            end
        end
        wait_idle(60);

        // Busy never rises: timeout, then next requester is served
        tx_mute = 1'b1;
        t0 = timeouts;
        new_req(1, 8'h3C, 1'b1, PAR_EVEN);
        new_req(2, 8'hC3, 1'b0, PAR_ODD);
        wait_launch(1, 10);
        tx_mute = 1'b0;
        wait_launch(1, 60);
        wait_idle(60);
        chk("timeout_pulses", timeouts - t0, 1);

        // Foreign busy in idle, request withdrawn before busy falls
        foreign_busy = 1'b1;
        d0 = dv_seen;
        new_req(1, 8'h77, 1'b0, PAR_EVEN);
        repeat (5) tick();
        req_valid[1] = 1'b0;
        tick();
        foreign_busy = 1'b0;
        repeat (10) tick();
        chk("no_launch_withdraw", dv_seen, d0);

        // Reset while waiting for busy to fall
        auto_mode = 1;
        b = 0;
        while (phase != 2 && b < 100) begin
            tick();
            b++;
        end
        chk("reached_wait_done", phase, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        gs = gseq.size();
        wait_launch(1, 20);
        if (gseq.size() > gs) chk("post_reset_grant", gseq[gs], 0);
        auto_mode = 0;
        req_valid = '0;
        wait_idle(60);

        // Randomized traffic with occasional withdraws and silent transmitter
        auto_mode = 2;
        repeat (1500) tick();
        auto_mode = 0;
        tx_mute = 1'b0;
        req_valid = '0;
        wait_idle(60);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
